// File: rtl/instr_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq_if
//   Bundles every non-clock signal of the instruction fetch/issue sequencer:
//   the instruction-memory read channel, the decoder/ALU feedback that
//   steers the next PC, and the issued-instruction outputs.
//
//   Parameters
//     PC_W     PC width in bits (byte address)
//     IMEM_AW  instruction-memory word-address width
//
//   Signals (direction given from the sequencer's point of view)
//     imem_req      out  fetch request, held until imem_rvalid
//     imem_addr     out  word address, stable while imem_req=1
//     imem_rvalid   in   read data valid, qualifies imem_rdata
//     imem_rdata    in   instruction word
//     stall_in      in   external hold of the issued instruction
//     zero          in   ALU zero flag for the issued instruction
//     branch_on_eq  in   decoder output
//     branch_on_neq in   decoder output
//     jump          in   decoder output
//     jr_target     in   rs register value, used by jump-register
//     instr         out  instruction register
//     opcode        out  instr[31:26], or the NOP opcode while nothing issues
//     funct         out  instr[5:0]
//     instr_valid   out  instr is issued this cycle
//     pc            out  address of instr
//     pc_plus4      out  pc+4, also the jal link value
//
//   Handshake: imem_req is the request and imem_rvalid the response. A
//   request is raised together with imem_addr and both stay unchanged until
//   the cycle in which imem_rvalid is seen high while imem_req is high; that
//   cycle completes the transfer and imem_rdata is captured. imem_rvalid
//   while imem_req is low carries no meaning and is ignored.
//
//   Modports
//     master  the sequencer
//     slave   the memory/decoder/datapath environment
// ---------------------------------------------------------------------------
interface instr_fetch_seq_if #(
  parameter int PC_W    = 32,
  parameter int IMEM_AW = 10
);
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_rvalid;
  logic [31:0]        imem_rdata;
  logic               stall_in;
  logic               zero;
  logic               branch_on_eq;
  logic               branch_on_neq;
  logic               jump;
  logic [PC_W-1:0]    jr_target;
  logic [31:0]        instr;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus4;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  stall_in, zero, branch_on_eq, branch_on_neq, jump, jr_target,
    output instr, opcode, funct, instr_valid, pc, pc_plus4
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output stall_in, zero, branch_on_eq, branch_on_neq, jump, jr_target,
    input  instr, opcode, funct, instr_valid, pc, pc_plus4
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq
//   Instruction fetch/issue sequencer sitting between instruction memory and
//   the control decoder/datapath. It fetches one word at a time, holds it in
//   the instruction register while it is issued, samples the decoder's
//   jump/branch outputs and the ALU zero flag during issue, and computes the
//   next PC. Fetching the halt opcode parks the sequencer until reset.
//
//   Parameters
//     PC_W          PC width in bits (byte address, at least 29)
//     IMEM_AW       imem word-address width; imem_addr = pc[IMEM_AW+1:2]
//     RESET_PC      PC loaded on reset
//     NOP_OPCODE    opcode presented while no instruction is issued
//     STALL_OPCODE  opcode that halts the sequencer
//
//   Ports
//     clk        clock
//     rst        synchronous, active-low reset
//     bus        instr_fetch_seq_if.master (imem channel, decoder feedback,
//                issued-instruction outputs)
//     state_dbg  current FSM state: 0 IDLE, 1 FETCH, 2 ISSUE, 3 HALT
//
//   Sequence: IDLE -> FETCH -> ISSUE -> FETCH ... ; ISSUE -> HALT on the
//   halt opcode. Best case throughput is one instruction every two cycles.
// ---------------------------------------------------------------------------
module instr_fetch_seq #(
  parameter int             PC_W         = 32,
  parameter int             IMEM_AW      = 10,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]     NOP_OPCODE   = 6'b111111,
  parameter logic [5:0]     STALL_OPCODE = 6'b000110
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_seq_if.master   bus,
  output logic [1:0]          state_dbg
);

  localparam logic [5:0] OP_JR  = 6'b000000;  // R-type; jump flags it as jr
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  logic [5:0]      instr_op;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] branch_off;
  logic [PC_W-1:0] next_pc;
  logic            take_branch;
  logic            is_jr;
  logic            is_jabs;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= {NOP_OPCODE, 26'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-PC computation. Only consumed in ISSUE, where instr_q holds the
  // issued instruction, so the raw opcode field is used here rather than the
  // NOP-masked output.
  // --------------------------------------------------------------------------
  assign instr_op   = instr_q[31:26];
  assign pc_plus4   = pc_q + PC_W'(4);
  assign branch_off = {{(PC_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};

  assign is_jr   = bus.jump && (instr_op == OP_JR);
  assign is_jabs = bus.jump && ((instr_op == OP_J) || (instr_op == OP_JAL));

  // The decoder raises branch_on_eq for ALU ops as well, so the branch is
  // only honoured when the opcode really is a branch.
  assign take_branch = ((instr_op == OP_BEQ) && bus.branch_on_eq  &&  bus.zero) ||
                       ((instr_op == OP_BNE) && bus.branch_on_neq && !bus.zero);

  always_comb begin
    next_pc = pc_plus4;
    if (is_jr) begin
      // Misaligned register targets are forced onto a word boundary.
      next_pc = {bus.jr_target[PC_W-1:2], 2'b00};
    end else if (is_jabs) begin
      next_pc = {pc_plus4[PC_W-1:28], instr_q[25:0], 2'b00};
    end else if (take_branch) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // The response may arrive in the very first FETCH cycle.
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.stall_in) begin
          if (instr_op == STALL_OPCODE) begin
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (all decoded from registered state, so no input-to-output paths)
  // --------------------------------------------------------------------------
  assign bus.imem_req    = (state_q == S_FETCH);
  assign bus.imem_addr   = pc_q[IMEM_AW+1:2];
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == S_ISSUE);
  assign bus.opcode      = (state_q == S_ISSUE) ? instr_q[31:26] : NOP_OPCODE;
  assign bus.funct       = instr_q[5:0];
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign state_dbg       = state_q;

  // jr_target's byte-offset bits are intentionally discarded.
  logic unused_jr_low;
  assign unused_jr_low = ^bus.jr_target[1:0];

`ifndef SYNTHESIS
  // An outstanding request keeps its address until the response arrives.
  a_req_stable: assert property (@(posedge clk) disable iff (!rst)
    (bus.imem_req && !bus.imem_rvalid) |=> (bus.imem_req && $stable(bus.imem_addr)));

  // HALT is only left through reset.
  a_halt_sticky: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_HALT) |=> (state_q == S_HALT));
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_seq
//   Self-checking bench for instr_fetch_seq. A queue holds the PC expected
//   for each upcoming fetch; it is pushed when an instruction is issued and
//   popped when the sequencer raises its next fetch request.
// ---------------------------------------------------------------------------
module tb_instr_fetch_seq;
  localparam int         PC_W     = 32;
  localparam int         IMEM_AW  = 10;
  localparam logic [5:0] NOP_OP   = 6'h3F;
  localparam logic [5:0] STALL_OP = 6'h06;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic [PC_W-1:0] exp_q[$];

  instr_fetch_seq_if #(.PC_W(PC_W), .IMEM_AW(IMEM_AW)) bus ();

  instr_fetch_seq #(
    .PC_W(PC_W), .IMEM_AW(IMEM_AW), .RESET_PC(32'h0),
    .NOP_OPCODE(6'h3F), .STALL_OPCODE(6'h06)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.imem_rvalid   = 1'b0;
    bus.imem_rdata    = 32'h0;
    bus.stall_in      = 1'b0;
    bus.zero          = 1'b0;
    bus.branch_on_eq  = 1'b0;
    bus.branch_on_neq = 1'b0;
    bus.jump          = 1'b0;
    bus.jr_target     = 32'h0;
  endtask

  // Bench-side next-PC model used for the random instruction mix.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                             input logic jmp, input logic beq, input logic bne,
                                             input logic z, input logic [31:0] jrt);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = cur + 32'd4;
    off = {{14{w[15]}}, w[15:0], 2'b00};
    if (jmp && w[31:26] == 6'd0) return {jrt[31:2], 2'b00};
    if (jmp && (w[31:26] == 6'd2 || w[31:26] == 6'd3)) return {p4[31:28], w[25:0], 2'b00};
    if ((w[31:26] == 6'd4 && beq && z) || (w[31:26] == 6'd5 && bne && !z)) return p4 + off;
    return p4;
  endfunction

  // ---------------- driver: one fetch/issue transaction ----------------
  // Entered just after a clock edge with the sequencer in (or about to be in)
  // FETCH; returns just after the edge that leaves ISSUE.
  task automatic run_instr(input logic [31:0] word, input int delay, input int stall,
                           input logic jmp, input logic beq, input logic bne, input logic z,
                           input logic [31:0] jrt, input logic [31:0] exp_next);
    logic [31:0]        exp_pc;
    logic [IMEM_AW-1:0] exp_addr;
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL fetch_timeout: imem_req=%b required 1", bus.imem_req); return;
    end
    if (exp_q.size() == 0) begin
      checks++; errors++; $display("FAIL sb_empty: no expected pc for fetch at pc=%h", bus.pc); return;
    end
    exp_pc   = exp_q.pop_front();
    exp_addr = exp_pc[IMEM_AW+1:2];
    checks++; if (bus.pc !== exp_pc) begin errors++; $display("FAIL fetch_pc: got %h required %h", bus.pc, exp_pc); end
    checks++; if (bus.imem_addr !== exp_addr) begin errors++; $display("FAIL fetch_addr: got %h required %h", bus.imem_addr, exp_addr); end
    for (int i = 0; i < delay; i++) begin
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin
        errors++; $display("FAIL wait_hold: req=%b addr=%h required req=1 addr=%h", bus.imem_req, bus.imem_addr, exp_addr);
      end
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = word;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL issue_valid: got %b required 1", bus.instr_valid); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL issue_req: got %b required 0", bus.imem_req); end
    checks++; if (bus.instr !== word) begin errors++; $display("FAIL issue_instr: got %h required %h", bus.instr, word); end
    checks++; if (bus.opcode !== word[31:26]) begin errors++; $display("FAIL issue_opcode: got %h required %h", bus.opcode, word[31:26]); end
    checks++; if (bus.funct !== word[5:0]) begin errors++; $display("FAIL issue_funct: got %h required %h", bus.funct, word[5:0]); end
    checks++; if (bus.pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL issue_pc4: got %h required %h", bus.pc_plus4, exp_pc + 32'd4); end
    bus.jump = jmp; bus.branch_on_eq = beq; bus.branch_on_neq = bne;
    bus.zero = z;   bus.jr_target = jrt;
    for (int i = 0; i < stall; i++) begin
      bus.stall_in    = 1'b1;
      bus.imem_rvalid = 1'b1;   // stray response outside FETCH must be ignored
      tick();
      bus.imem_rvalid = 1'b0;
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.pc !== exp_pc || bus.instr !== word) begin
        errors++; $display("FAIL stall_hold: valid=%b pc=%h instr=%h required 1 %h %h", bus.instr_valid, bus.pc, bus.instr, exp_pc, word);
      end
    end
    bus.stall_in = 1'b0;
    tick();
    clear_inputs();
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL post_valid: got %b required 0", bus.instr_valid); end
    if (word[31:26] == STALL_OP) begin
      checks++; if (bus.imem_req !== 1'b0 || bus.pc !== exp_pc) begin
        errors++; $display("FAIL halt_enter: req=%b pc=%h required 0 %h", bus.imem_req, bus.pc, exp_pc);
      end
    end else begin
      exp_q.push_back(exp_next);
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL post_req: got %b required 1", bus.imem_req); end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h required 0", bus.pc); end
    checks++; if (bus.opcode !== NOP_OP) begin errors++; $display("FAIL rst_opcode: got %h required %h", bus.opcode, NOP_OP); end
    checks++; if (bus.instr !== 32'hFC00_0000) begin errors++; $display("FAIL rst_instr: got %h required fc000000", bus.instr); end
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_ctrl: valid=%b req=%b required 0 0", bus.instr_valid, bus.imem_req);
    end
    tick();
    tick();
    rst = 1'b1;
    checks++; if (state_dbg !== ST_IDLE || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_idle: state=%0d req=%b required %0d 0", state_dbg, bus.imem_req, ST_IDLE);
    end
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd0 || state_dbg !== ST_FETCH) begin
      errors++; $display("FAIL rst_first_fetch: req=%b addr=%h state=%0d required 1 0 %0d", bus.imem_req, bus.imem_addr, state_dbg, ST_FETCH);
    end
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  task automatic test_first_fetch();
    run_instr(32'h0022_1820, 0, 0, 0, 0, 0, 0, 32'h0, 32'h4);
    checks++; if (bus.imem_addr !== 10'd1) begin errors++; $display("FAIL next_addr: got %h required 1", bus.imem_addr); end
    run_instr(32'h0022_1820, 0, 0, 0, 0, 0, 0, 32'h0, 32'h8);
    run_instr(32'h0022_1820, 0, 0, 0, 0, 0, 0, 32'h0, 32'hC);
    run_instr(32'h0022_1820, 0, 0, 0, 0, 0, 0, 32'h0, 32'h10);
  endtask

  task automatic test_branch();
    run_instr(32'h1000_0003, 0, 0, 0, 1, 0, 1, 32'h0, 32'h20);   // beq taken
    run_instr(32'h0800_0004, 0, 0, 1, 0, 0, 0, 32'h0, 32'h10);   // j back to 0x10
    run_instr(32'h1000_0003, 0, 0, 0, 1, 0, 0, 32'h0, 32'h14);   // beq not taken
    run_instr(32'h0800_0004, 0, 0, 1, 0, 0, 0, 32'h0, 32'h10);
    run_instr(32'h1000_FFFE, 0, 0, 0, 1, 0, 1, 32'h0, 32'hC);    // backward branch
    run_instr(32'h0022_1820, 0, 0, 0, 0, 0, 0, 32'h0, 32'h10);
  endtask

  task automatic test_jump();
    run_instr(32'h0800_0040, 0, 0, 1, 0, 0, 0, 32'h0,         32'h100);
    run_instr(32'h03E0_0008, 0, 0, 1, 0, 0, 0, 32'h203,       32'h200);
    run_instr(32'h03E0_0008, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    run_instr(32'h0022_1820, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0);    // pc wraps
    run_instr(32'h0800_0004, 0, 0, 1, 0, 0, 0, 32'h0,         32'h10);
    run_instr(32'h0022_1820, 0, 0, 0, 1, 0, 1, 32'h0,         32'h14);   // add ignores beq
    run_instr(32'h0C00_0008, 0, 0, 1, 0, 0, 0, 32'h0,         32'h20);   // jal
  endtask

  task automatic test_branch_neq();
    run_instr(32'h1400_0002, 0, 0, 0, 0, 1, 0, 32'h0, 32'h2C);
    run_instr(32'h1400_0002, 0, 0, 0, 0, 1, 1, 32'h0, 32'h30);
  endtask

  task automatic test_fetch_wait();
    run_instr(32'h0022_1820, 3, 0, 0, 0, 0, 0, 32'h0, 32'h34);
  endtask

  task automatic test_stall();
    run_instr(32'h0022_1820, 0, 2, 0, 0, 0, 0, 32'h0, 32'h38);
  endtask

  task automatic test_random();
    logic [5:0]  ops [6];
    logic [31:0] w, jrt, cur;
    logic        jmp, beq, bne, z;
    ops[0] = 6'd0; ops[1] = 6'd2; ops[2] = 6'd3; ops[3] = 6'd4; ops[4] = 6'd5; ops[5] = 6'd8;
    for (int i = 0; i < 12; i++) begin
      w   = {ops[$urandom_range(0, 5)], 26'($urandom)};
      jrt = $urandom;
      jmp = 1'($urandom_range(0, 1));
      beq = 1'($urandom_range(0, 1));
      bne = 1'($urandom_range(0, 1));
      z   = 1'($urandom_range(0, 1));
      cur = exp_q[0];
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), jmp, beq, bne, z, jrt,
                model_next(cur, w, jmp, beq, bne, z, jrt));
    end
  endtask

  task automatic test_halt();
    logic [31:0] hpc;
    hpc = exp_q[0];
    run_instr(32'h1800_0000, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 22; i++) begin
      bus.imem_rvalid = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== hpc ||
          bus.opcode !== NOP_OP || state_dbg !== ST_HALT) begin
        errors++; $display("FAIL halt_hold: req=%b valid=%b pc=%h op=%h state=%0d required 0 0 %h %h %0d",
                           bus.imem_req, bus.instr_valid, bus.pc, bus.opcode, state_dbg, hpc, NOP_OP, ST_HALT);
      end
    end
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    run_instr(32'h0022_1820, 0, 0, 0, 0, 0, 0, 32'h0, 32'h4);
    tick();                         // request outstanding at pc=4
    rst = 1'b0;
    tick();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 32'h0 || state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL mid_fetch_rst: req=%b pc=%h state=%0d required 0 0 %0d", bus.imem_req, bus.pc, state_dbg, ST_IDLE);
    end
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h0);
    tick();
    run_instr(32'h0022_1820, 1, 0, 0, 0, 0, 0, 32'h0, 32'h4);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump();
    test_branch_neq();
    test_fetch_wait();
    test_stall();
    test_random();
    test_halt();
    test_reset();                   // restart from HALT
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
